// File: rtl/dds_symbol_packer.sv
// Byte-to-symbol packer feeding the DDS controller.
// Three accepted bytes form a 24-bit word that waits in a 2-deep buffer.
// On each pacing tick the head word is popped and shown as four 6-bit symbols.
module dds_symbol_packer #(
    parameter int unsigned SYM_PERIOD = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Enable,
    input  logic        Flush,
    input  logic        In_Valid,
    input  logic [7:0]  In_Data,
    output logic        In_Ready,
    output logic        TransValid,
    output logic [5:0]  Trans0Data,
    output logic [5:0]  Trans1Data,
    output logic [5:0]  Trans2Data,
    output logic [5:0]  Trans3Data,
    output logic        Busy,
    output logic [15:0] Underrun
);

    localparam logic [5:0] LP_LAST = 6'(SYM_PERIOD - 1);

    logic [1:0]  r_idx;
    logic [7:0]  r_byte0;
    logic [7:0]  r_byte1;
    logic [23:0] r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic [5:0]  r_per_cnt;
    logic        r_flush_pend;
    logic        r_trans_valid;
    logic [23:0] r_sym;
    logic [15:0] r_underrun;

    logic        w_tick;
    logic        w_accept;
    logic        w_pop;
    logic        w_flush_push;
    logic        w_byte_push;
    logic        w_push;
    logic [23:0] w_push_word;
    logic [7:0]  w_pad_byte1;

    // Handshake, pacing tick and buffer push/pop decisions
    always_comb begin
        In_Ready     = (r_count < 2'd2) && !r_flush_pend;
        w_accept     = In_Valid && In_Ready;
        w_tick       = Enable && (r_per_cnt == LP_LAST);
        w_pop        = w_tick && (r_count != 2'd0);
        // In_Ready is low while a flush is pending, so the two push sources never collide
        w_flush_push = r_flush_pend && (r_idx != 2'd0) && (r_count < 2'd2);
        w_byte_push  = w_accept && (r_idx == 2'd2);
        w_push       = w_flush_push || w_byte_push;
        // r_byte1 may be stale when only one byte is held, so pad it explicitly
        w_pad_byte1  = (r_idx == 2'd2) ? r_byte1 : 8'h00;
        w_push_word  = w_flush_push ? {r_byte0, w_pad_byte1, 8'h00}
                                    : {r_byte0, r_byte1, In_Data};
        Busy         = (r_count != 2'd0) || (r_idx != 2'd0);
        TransValid   = r_trans_valid;
        Trans0Data   = r_sym[23:18];
        Trans1Data   = r_sym[17:12];
        Trans2Data   = r_sym[11:6];
        Trans3Data   = r_sym[5:0];
        Underrun     = r_underrun;
    end

    // Byte assembler: collects the first two bytes, third byte goes straight to the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_byte0 <= 8'h00;
            r_byte1 <= 8'h00;
        end else if (w_accept) begin
            case (r_idx)
                2'd0: begin
                    r_byte0 <= In_Data;
                    r_idx   <= 2'd1;
                end
                2'd1: begin
                    r_byte1 <= In_Data;
                    r_idx   <= 2'd2;
                end
                default: r_idx <= 2'd0;
            endcase
        end else if (w_flush_push) begin
            r_idx <= 2'd0;
        end
    end

    // Flush request: held until the partial word has been pushed or nothing is left
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_pend <= 1'b0;
        end else if (Flush) begin
            r_flush_pend <= 1'b1;
        end else if (r_flush_pend && ((r_idx == 2'd0) || w_flush_push)) begin
            r_flush_pend <= 1'b0;
        end
    end

    // Two-entry word buffer; push is gated on the pre-pop count so it never overflows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= 24'h0;
            r_mem[1] <= 24'h0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_word;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Symbol period counter, held at zero while pacing is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_cnt <= 6'd0;
        end else if (!Enable || (r_per_cnt == LP_LAST)) begin
            r_per_cnt <= 6'd0;
        end else begin
            r_per_cnt <= r_per_cnt + 6'd1;
        end
    end

    // Symbol outputs: strobe for one cycle and latch the popped word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trans_valid <= 1'b0;
            r_sym         <= 24'h0;
        end else begin
            r_trans_valid <= w_pop;
            if (w_pop) begin
                r_sym <= r_mem[r_rd_ptr];
            end
        end
    end

    // Missed slots are counted only when a word is partly assembled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun <= 16'h0;
        end else if (w_tick && (r_count == 2'd0) && (r_idx != 2'd0) &&
                     (r_underrun != 16'hFFFF)) begin
            r_underrun <= r_underrun + 16'd1;
        end
    end

endmodule

// File: tb/tb_dds_symbol_packer.sv
// Randomized and directed bench for dds_symbol_packer with a queue-based reference model.
module tb_dds_symbol_packer;

    localparam int SP = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        trans_valid;
    logic [5:0]  t0, t1, t2, t3;
    logic        busy;
    logic [15:0] underrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state
    logic [23:0] mq[$];
    logic [7:0]  mp[$];
    int          m_cnt;
    bit          m_pend;
    bit          m_tv;
    logic [23:0] m_out;
    int          m_und;

    // Strobe log
    int          st_cyc[$];
    logic [23:0] st_word[$];

    dds_symbol_packer #(.SYM_PERIOD(SP)) dut (
        .clk        (clk),
        .rst        (rst),
        .Enable     (enable),
        .Flush      (flush),
        .In_Valid   (in_valid),
        .In_Data    (in_data),
        .In_Ready   (in_ready),
        .TransValid (trans_valid),
        .Trans0Data (t0),
        .Trans1Data (t1),
        .Trans2Data (t2),
        .Trans3Data (t3),
        .Busy       (busy),
        .Underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mp.delete();
        m_cnt  = 0;
        m_pend = 0;
        m_tv   = 0;
        m_out  = 24'h0;
        m_und  = 0;
    endtask

    // One clock of the packer described as word/byte queues
    task automatic model_step();
        int          qs;
        bit          rdy;
        bit          tick;
        logic [7:0]  b1;
        qs   = mq.size();
        rdy  = (qs < 2) && !m_pend;
        tick = enable && (m_cnt == SP - 1);
        m_tv = 0;
        if (tick) begin
            if (qs > 0) begin
                m_out = mq.pop_front();
                m_tv  = 1;
            end else if (mp.size() != 0 && m_und < 65535) begin
                m_und++;
            end
        end
        if (m_pend) begin
            if (mp.size() == 0) begin
                m_pend = 0;
            end else if (qs < 2) begin
                b1 = (mp.size() > 1) ? mp[1] : 8'h00;
                mq.push_back({mp[0], b1, 8'h00});
                mp.delete();
                m_pend = 0;
            end
        end
        if (in_valid && rdy) begin
            mp.push_back(in_data);
            if (mp.size() == 3) begin
                mq.push_back({mp[0], mp[1], mp[2]});
                mp.delete();
            end
        end
        if (flush) m_pend = 1;
        if (!enable || m_cnt == SP - 1) m_cnt = 0;
        else m_cnt = m_cnt + 1;
    endtask

    // Compare at the falling edge, advance the model, then move past the rising edge
    task automatic step();
        @(negedge clk);
        if (rst) model_reset();
        chk("in_ready", 32'(in_ready), 32'((mq.size() < 2) && !m_pend));
        chk("trans_valid", 32'(trans_valid), 32'(m_tv));
        chk("symbols", 32'({t0, t1, t2, t3}), 32'(m_out));
        chk("busy", 32'(busy), 32'((mq.size() != 0) || (mp.size() != 0)));
        chk("underrun", 32'(underrun), 32'(m_und));
        if (!rst) model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (trans_valid) begin
            st_cyc.push_back(cyc);
            st_word.push_back({t0, t1, t2, t3});
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        st_cyc.delete();
        st_word.delete();
    endtask

    task automatic feed_byte(input logic [7:0] b);
        bit acc;
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 100 && !done; i++) begin
            acc = in_ready;
            step();
            if (acc) done = 1;
        end
        in_valid = 1'b0;
        if (!done) chk("feed_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_strobes(input int n, input int max_steps);
        for (int i = 0; i < max_steps && st_cyc.size() < n; i++) step();
        chk("strobe_count", 32'(st_cyc.size()), 32'(n));
    endtask

    logic [7:0]  bytes12 [12];
    logic [23:0] w_exp;
    bit          seen;
    int          first;

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        model_reset();

        // Reset state and a single packed word
        do_reset();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        feed_byte(8'hA5);
        feed_byte(8'h3C);
        feed_byte(8'h0F);
        wait_strobes(1, 60);
        if (st_word.size() > 0) chk("t1_word", 32'(st_word[0]), 32'h00A53C0F);
        step();
        chk("t1_busy_after", 32'(busy), 32'd0);

        // Twelve bytes back to back: pacing, order and back-pressure
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 12; k++) bytes12[k] = 8'($urandom);
        for (int k = 0; k < 12; k++) feed_byte(bytes12[k]);
        wait_strobes(4, 200);
        if (st_cyc.size() >= 4) begin
            for (int k = 1; k < 4; k++) chk("t2_spacing", 32'(st_cyc[k] - st_cyc[k-1]), 32'(SP));
            for (int k = 0; k < 4; k++) begin
                w_exp = {bytes12[3*k], bytes12[3*k+1], bytes12[3*k+2]};
                chk("t2_word", 32'(st_word[k]), 32'(w_exp));
            end
        end
        chk("t2_underrun", 32'(underrun), 32'd0);

        // Flush of a two-byte partial word
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        feed_byte(8'hFF);
        feed_byte(8'hFF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t3_ready_pend", 32'(in_ready), 32'd0);
        wait_strobes(1, 60);
        if (st_word.size() > 0) chk("t3_word", 32'(st_word[0]), 32'h00FFFF00);

        // Starved partial word counts underruns, then flushes out
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        feed_byte(8'h5A);
        for (int i = 0; i < 75; i++) step();
        chk("t4_no_strobe", 32'(st_cyc.size()), 32'd0);
        chk("t4_underrun", 32'(underrun), 32'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_strobes(1, 60);
        if (st_word.size() > 0) chk("t4_word", 32'(st_word[0]), 32'h005A0000);

        // Enable dropped mid-period with two words buffered
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 6; k++) bytes12[k] = 8'($urandom);
        for (int k = 0; k < 6; k++) feed_byte(bytes12[k]);
        for (int i = 0; i < 4; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("t5_no_strobe_low", 32'(st_cyc.size()), 32'd0);
        enable = 1'b1;
        first = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (trans_valid && first < 0) first = i;
        end
        chk("t5_reenable_delay", 32'(first), 32'(SP));
        wait_strobes(2, 60);
        if (st_word.size() >= 2) begin
            chk("t5_word0", 32'(st_word[0]), 32'({bytes12[0], bytes12[1], bytes12[2]}));
            chk("t5_word1", 32'(st_word[1]), 32'({bytes12[3], bytes12[4], bytes12[5]}));
        end

        // Reset in the middle of a word
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        feed_byte(8'h11);
        feed_byte(8'h22);
        rst = 1'b1;
        step();
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_tv", 32'(trans_valid), 32'd0);
        chk("t6_sym", 32'({t0, t1, t2, t3}), 32'd0);
        chk("t6_underrun", 32'(underrun), 32'd0);
        rst = 1'b0;
        st_cyc.delete();
        st_word.delete();
        feed_byte(8'hC3);
        feed_byte(8'h96);
        feed_byte(8'h69);
        wait_strobes(1, 60);
        if (st_word.size() > 0) chk("t6_word", 32'(st_word[0]), 32'h00C39669);

        // Random traffic with flushes, enable toggles and rare resets
        enable = 1'b1;
        for (int seg = 0; seg < 10; seg++) begin
            int p;
            p = int'($urandom_range(10, 100));
            for (int i = 0; i < 300; i++) begin
                in_valid = ($urandom_range(0, 99) < p);
                in_data  = 8'($urandom);
                flush    = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 199) == 0) enable = ~enable;
                rst      = ($urandom_range(0, 999) == 0);
                step();
            end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        for (int i = 0; i < 60; i++) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
